// File: rtl/div_pkg.sv
// Shared definitions for the iterative integer divider: operation codes,
// FSM state encoding and the default operand width.
package div_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_CALC = 2'b10,
        ST_FIN  = 2'b11
    } div_state_e;

    // DIV and REM interpret operands as two's complement.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration: shift the next dividend bit into
// the partial remainder, compare against the divisor, subtract when it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic          fits;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        fits    = (shifted >= {1'b0, divisor});
        // When the divisor fits, the difference is below 2^XLEN, so the low
        // XLEN bits of the subtraction are exact.
        if (fits) begin
            rem_out = shifted[XLEN-1:0] - divisor;
        end else begin
            rem_out = shifted[XLEN-1:0];
        end
        quo_out = {quo_in[XLEN-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle integer divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to let divide-by-zero and signed overflow skip CALC.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write,
    output div_state_e      dbg_state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Handshake: start is a request sampled only in IDLE (no queueing, no
    // ready); done/reg_write is a single-cycle valid with no back-pressure.

    div_state_e      state;
    div_state_e      state_next;

    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvsr_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_out_q;

    logic            is_signed;
    logic            div_zero;
    logic            sgn_ovf;
    logic            early_out;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;
    logic [XLEN-1:0] fin_value;

    assign is_signed = op_is_signed(op_q);
    assign div_zero  = (b_q == '0);
    assign sgn_ovf   = is_signed && (a_q == MOST_NEG) && (b_q == '1);
    assign a_abs     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
    assign b_abs     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = div_zero || sgn_ovf;
`else
    assign early_out = 1'b0;
`endif

    div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_in (rem_q),
        .quo_in (quo_q),
        .divisor(dvsr_q),
        .rem_out(rem_nx),
        .quo_out(quo_nx)
    );

    // Special cases are resolved from the captured operands so the result is
    // correct whether or not CALC ran.
    always_comb begin
        quo_fin = q_neg_q ? -quo_q : quo_q;
        rem_fin = r_neg_q ? -rem_q : rem_q;
        if (div_zero) begin
            quo_fin = '1;
            rem_fin = a_q;
        end else if (sgn_ovf) begin
            quo_fin = a_q;
            rem_fin = '0;
        end
        fin_value = op_is_rem(op_q) ? rem_fin : quo_fin;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && !flush) state_next = ST_PREP;
            end
            ST_PREP: begin
                if (flush)          state_next = ST_IDLE;
                else if (early_out) state_next = ST_FIN;
                else                state_next = ST_CALC;
            end
            ST_CALC: begin
                if (flush)             state_next = ST_IDLE;
                else if (cnt_q == '0)  state_next = ST_FIN;
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        op_q <= op;
                        a_q  <= rs1_data;
                        b_q  <= rs2_data;
                        rd_q <= rd_in;
                    end
                end
                ST_PREP: begin
                    quo_q   <= a_abs;
                    dvsr_q  <= b_abs;
                    rem_q   <= '0;
                    q_neg_q <= is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    r_neg_q <= is_signed && a_q[XLEN-1];
                    cnt_q   <= CW'(XLEN - 1);
                end
                ST_CALC: begin
                    quo_q <= quo_nx;
                    rem_q <= rem_nx;
                    cnt_q <= (cnt_q == '0) ? '0 : cnt_q - CW'(1);
                end
                ST_FIN: begin
                    if (!flush) begin
                        result_q <= fin_value;
                        rd_out_q <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // The result is presented in the FIN cycle itself and then held.
    assign done      = (state == ST_FIN) && !flush && !reset;
    assign reg_write = done;
    assign busy      = (state != ST_IDLE);
    assign result    = done ? fin_value : result_q;
    assign rd_out    = done ? rd_q : rd_out_q;
    assign dbg_state = state;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 rs1_data  input  XLEN  dividend, from register file read port 1.
REQ-007 rs2_data  input  XLEN  divisor, from register file read port 2.
REQ-008 rd_in  input  5  destination register index.
REQ-009 flush  input  1  abort the in-flight operation.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle result-valid pulse.
REQ-012 result  output  XLEN  quotient or remainder; drives register file Data.
REQ-013 rd_out  output  5  captured rd_in; drives register file rd.
REQ-014 reg_write  output  1  equal to done; drives register file regWrite.

Function
REQ-015 FSM states: IDLE, PREP, CALC, FIN.
REQ-016 IDLE & start & !flush -> PREP; capture op, rs1_data, rs2_data, rd_in; later operand changes are ignored.
REQ-017 PREP: signed ops take absolute values and record quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign); -> CALC; iteration counter = XLEN-1.
REQ-018 CALC: restoring radix-2 step, one quotient bit per cycle, MSB first; counter decrements; after counter 0 -> FIN.
REQ-019 FIN: apply sign correction, select quotient (DIV/DIVU) or remainder (REM/REMU), assert done=1 for exactly this cycle; -> IDLE.
REQ-020 Latency: done is high exactly XLEN+2 cycles after the edge that accepted start (XLEN=32: 34 cycles).
REQ-021 result and rd_out hold their values from FIN until the next FIN or reset.
REQ-022 start while busy is ignored; no queueing.
REQ-023 Divide by zero: quotient = all ones (DIV and DIVU), remainder = dividend.
REQ-024 Signed overflow (dividend = most negative, divisor = -1, DIV/REM): quotient = dividend, remainder = 0.
REQ-025 Sign rule: remainder sign follows the dividend; quotient truncates toward zero.
REQ-026 flush in any non-IDLE state -> IDLE next cycle with no done; flush in FIN suppresses done that cycle.
REQ-027 flush and start in the same IDLE cycle: flush wins, the request is dropped.
REQ-028 rd_in = 0 is processed normally with reg_write asserted; the register file discards the write to x0.

Reset
REQ-029 reset -> IDLE from any state, including mid-CALC; the in-flight result is discarded.
REQ-030 Reset values: busy=0, done=0, reg_write=0, result=0, rd_out=0, counter=0.
REQ-031 reset has priority over flush and start.

Configuration
REQ-032 Macro DIV_EARLY_OUT_EN defined: divide-by-zero and signed-overflow cases go PREP -> FIN, skipping CALC, so done comes 2 cycles after accept.
REQ-033 Macro DIV_EARLY_OUT_EN undefined: these cases take the full XLEN+2 latency; results are the same per REQ-023/024.

Structure
REQ-034 Shared package div_pkg holds: op encodings, FSM state enum, and the XLEN default constant.
REQ-035 One sub-module, div_step, implements one combinational shift/compare/subtract iteration and is instantiated once inside CALC datapath.

Verification
REQ-036 DIVU 100 / 7 -> done at cycle 34, result 14, reg_write=1 one cycle, rd_out=rd_in.
REQ-037 REM -7 / 2 -> result 0xFFFFFFFF (-1); DIV -7 / 2 -> 0xFFFFFFFD (-3).
REQ-038 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; with DIV_EARLY_OUT_EN done at cycle 2, otherwise at cycle 34.
REQ-039 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
REQ-040 Pulse start again at cycle 10 while busy -> ignored, one done only; flush at cycle 20 -> no done, busy=0 at cycle 21.
REQ-041 reset at cycle 15 mid-CALC -> all outputs 0 next cycle; a new start after reset completes correctly.
